// File: rtl/byte_assembler.sv
// byte_assembler: serial-to-parallel word assembler with a one-entry
// valid/ready output holding register and a sticky overflow flag.
// Optional feature macro: BYTE_ASSEMBLER_PARITY_CHECK_EN adds a trailing
// even-parity bit per word, checked into parity_err.
module byte_assembler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [3:0]       bit_count,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_count;
  logic [WIDTH-1:0] r_byte;
  logic             r_valid;
  logic             r_overflow;
  logic             r_perr;

  logic [WIDTH-1:0] w_base_shift;
  logic [3:0]       w_base_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_in_parity;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;

  // frame_start discards the partial word before the current bit is applied,
  // so a bit sampled together with frame_start becomes bit 0 of a new word.
  always_comb begin
    w_base_shift = frame_start ? '0 : r_shift;
    w_base_cnt   = frame_start ? '0 : r_count;
    w_in_parity  = (r_state == PARITY) && !frame_start;
    if (MSB_FIRST != 0) begin
      w_shifted = {w_base_shift[WIDTH-2:0], bit_in};
    end else begin
      w_shifted = {bit_in, w_base_shift[WIDTH-1:1]};
    end
    w_last = (w_base_cnt == LAST) && !w_in_parity;
`ifdef BYTE_ASSEMBLER_PARITY_CHECK_EN
    w_done = bit_valid && w_in_parity;
    w_word = r_shift;
    w_perr = ^{r_shift, bit_in};
`else
    w_done = bit_valid && w_last;
    w_word = w_shifted;
    w_perr = 1'b0;
`endif
  end

  // Collection FSM, output holding register and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_count    <= '0;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if (bit_valid) begin
        if (w_in_parity) begin
          r_state <= IDLE;
          r_count <= '0;
          r_shift <= '0;
        end else if (w_last) begin
          r_count <= '0;
`ifdef BYTE_ASSEMBLER_PARITY_CHECK_EN
          r_state <= PARITY;
          r_shift <= w_shifted;
`else
          r_state <= IDLE;
          r_shift <= '0;
`endif
        end else begin
          r_state <= COLLECT;
          r_count <= w_base_cnt + 4'd1;
          r_shift <= w_shifted;
        end
      end else if (frame_start) begin
        r_state <= IDLE;
        r_count <= '0;
        r_shift <= '0;
      end

      // A completing word is accepted if the slot is empty or being drained
      // on this same edge; otherwise it is dropped and flagged.
      if (w_done && (!r_valid || byte_ready)) begin
        r_byte  <= w_word;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else if (r_valid && byte_ready) begin
        r_valid <= 1'b0;
      end

      if (w_done && r_valid && !byte_ready) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign byte_out   = r_byte;
  assign byte_valid = r_valid;
  assign overflow   = r_overflow;
  assign bit_count  = r_count;
`ifdef BYTE_ASSEMBLER_PARITY_CHECK_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_assembler.sv
// Directed bench for byte_assembler (default build: WIDTH=8, MSB_FIRST=1,
// parity feature disabled).
module tb_byte_assembler;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       overflow;
  logic       overflow_clr;
  logic [3:0] bit_count;
  logic       parity_err;

  int unsigned n_vec;
  int unsigned n_err;

  byte_assembler #(
    .WIDTH     (8),
    .MSB_FIRST (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .bit_count    (bit_count),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[7-i]);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [15:0] stream;
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    frame_start  = 1'b0;
    byte_ready   = 1'b0;
    overflow_clr = 1'b0;
    #12;
    reset = 1'b0;
    check("rst_byte_out", 16'(byte_out), 16'h00);
    check("rst_valid", 16'(byte_valid), 16'h0);
    check("rst_count", 16'(bit_count), 16'h0);
    check("rst_ovf", 16'(overflow), 16'h0);
    check("rst_perr", 16'(parity_err), 16'h0);
    step();

    // Asynchronous reset mid-word, between clock edges
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("mid_count3", 16'(bit_count), 16'h3);
    #2 reset = 1'b1;
    #1;
    check("async_byte_out", 16'(byte_out), 16'h00);
    check("async_valid", 16'(byte_valid), 16'h0);
    check("async_count", 16'(bit_count), 16'h0);
    check("async_ovf", 16'(overflow), 16'h0);
    #2 reset = 1'b0;
    step();
    send_word(8'hA5);
    check("post_rst_word", 16'(byte_out), 16'hA5);
    check("post_rst_valid", 16'(byte_valid), 16'h1);
    byte_ready = 1'b1;
    step();
    byte_ready = 1'b0;
    check("drain_valid", 16'(byte_valid), 16'h0);
    check("drain_hold", 16'(byte_out), 16'hA5);

    // MSB-first assembly with bit_count progression
    pat = 8'b0011_1000;
    for (int i = 0; i < 8; i++) begin
      send_bit(pat[7-i]);
      check("asm_count", 16'(bit_count), 16'((i + 1) % 8));
      if (i < 7) check("asm_valid_low", 16'(byte_valid), 16'h0);
    end
    check("asm_byte", 16'(byte_out), 16'h38);
    check("asm_valid", 16'(byte_valid), 16'h1);
    check("asm_ovf", 16'(overflow), 16'h0);

    // Overflow: second word dropped, old word held
    send_word(8'hFF);
    check("ovf_hold", 16'(byte_out), 16'h38);
    check("ovf_valid", 16'(byte_valid), 16'h1);
    check("ovf_set", 16'(overflow), 16'h1);
    step();
    check("ovf_sticky", 16'(overflow), 16'h1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_clr", 16'(overflow), 16'h0);
    check("ovf_clr_hold", 16'(byte_out), 16'h38);

    // Accept and completion on the same edge: no bubble, no overflow
    pat = 8'hC3;
    for (int i = 0; i < 7; i++) send_bit(pat[7-i]);
    check("same_hold", 16'(byte_out), 16'h38);
    byte_ready = 1'b1;
    send_bit(pat[0]);
    byte_ready = 1'b0;
    check("same_byte", 16'(byte_out), 16'hC3);
    check("same_valid", 16'(byte_valid), 16'h1);
    check("same_ovf", 16'(overflow), 16'h0);
    byte_ready = 1'b1;
    step();
    check("same_drain", 16'(byte_valid), 16'h0);

    // Back-to-back words with consumer always ready
    stream = 16'hF0A5;
    for (int i = 0; i < 16; i++) begin
      send_bit(stream[15-i]);
      check("b2b_valid", 16'(byte_valid), (i == 7 || i == 15) ? 16'h1 : 16'h0);
      if (i == 7)  check("b2b_first", 16'(byte_out), 16'hF0);
      if (i == 15) check("b2b_second", 16'(byte_out), 16'hA5);
    end
    step();
    check("b2b_end_valid", 16'(byte_valid), 16'h0);
    check("b2b_ovf", 16'(overflow), 16'h0);
    byte_ready = 1'b0;

    // frame_start with a bit on the same edge realigns the word
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    check("fs_count", 16'(bit_count), 16'h1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("fs_byte", 16'(byte_out), 16'h80);
    check("fs_valid", 16'(byte_valid), 16'h1);

    // frame_start alone clears the count but leaves the output untouched
    send_bit(1'b1); send_bit(1'b1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs_only_count", 16'(bit_count), 16'h0);
    check("fs_only_byte", 16'(byte_out), 16'h80);
    check("fs_only_valid", 16'(byte_valid), 16'h1);
    check("fs_only_ovf", 16'(overflow), 16'h0);

    // Idle bit_valid=0 cycles change nothing
    send_bit(1'b1);
    step(); step();
    check("idle_count", 16'(bit_count), 16'h1);
    check("perr_const", 16'(parity_err), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
